// File: rtl/fft_sample_loader_if.sv
// Sample sink (valid/ready) and Avalon-MM write-master signals of the FFT sample loader.
// master = loader side, slave = source/interconnect side.
interface fft_sample_loader_if #(
  parameter int ADDR_W = 10
);
  logic [15:0]       snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;

  modport master (
    input  snk_data, snk_valid, avm_waitrequest,
    output snk_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output snk_data, snk_valid, avm_waitrequest,
    input  snk_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/fft_sample_loader.sv
// Packs 2^ADDR_W audio samples into complex words and writes them to FFT RAM; 1-cycle sample-to-write latency,
// snk_ready drops while a write is stalled or on abort. FFT_LOADER_BITREV_EN selects bit-reversed addressing.
module fft_sample_loader #(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  fft_sample_loader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frames_loaded
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic              aborting_q;
  logic              done_nxt;
  logic              wr_stall;
  logic              xfer;
  logic              last_idx;

  assign wr_stall = bus.avm_write & bus.avm_waitrequest;
  assign xfer     = bus.snk_valid & bus.snk_ready;
  assign last_idx = (idx_q == {ADDR_W{1'b1}});

`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    addr_nxt = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      addr_nxt[i] = idx_q[ADDR_W-1-i];
    end
  end
`else
  assign addr_nxt = idx_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // An abort with a stalled write parks in FLUSH so the write is never withdrawn.
  always_comb begin
    state_nxt = state_q;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (abort) begin
          state_nxt = wr_stall ? FLUSH : IDLE;
        end else if (xfer && last_idx) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (!wr_stall) begin
          state_nxt = IDLE;
          done_nxt  = ~aborting_q & ~abort;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.snk_ready      = (state_q == CAPTURE) & ~abort & ~wr_stall;
    bus.avm_byteenable = bus.avm_write ? 4'hF : 4'h0;
    busy               = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q             <= '0;
      aborting_q        <= 1'b0;
      done              <= 1'b0;
      frames_loaded     <= 16'h0000;
      bus.avm_write     <= 1'b0;
      bus.avm_address   <= '0;
      bus.avm_writedata <= 32'h0000_0000;
    end else begin
      done <= done_nxt;
      if (done_nxt) frames_loaded <= frames_loaded + 16'd1;

      if (state_q == IDLE) begin
        idx_q      <= '0;
        aborting_q <= 1'b0;
      end else if (abort) begin
        aborting_q <= 1'b1;
      end

      // A new sample may be taken in the same cycle the previous write is accepted.
      if (xfer) begin
        idx_q             <= idx_q + ADDR_W'(1);
        bus.avm_address   <= addr_nxt;
        bus.avm_writedata <= {16'h0000, bus.snk_data};
        bus.avm_write     <= 1'b1;
      end else if (!wr_stall) begin
        bus.avm_write     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: random stimulus, frame-level reference model and a write/done scoreboard.
module tb_fft_sample_loader;
  localparam int ADDR_W = 10;
  localparam int N      = 1 << ADDR_W;
  localparam int M_IDLE  = 0;
  localparam int M_CAP   = 1;
  localparam int M_FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] frames_loaded;

  fft_sample_loader_if #(.ADDR_W(ADDR_W)) bus ();

  fft_sample_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .frames_loaded(frames_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  tests = 0;
  int  fails = 0;

  // Reference model: frame phase, samples taken so far, outstanding write.
  int m_phase = M_IDLE;
  int m_cnt = 0;
  bit m_pend = 1'b0;
  bit m_aborted = 1'b0;
  int m_frames = 0;
  int m_pend_idx = -1;
  int first_xfer_cyc = 0;
  int done_seen_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input int idx);
    int r;
    r = idx;
`ifdef FFT_LOADER_BITREV_EN
    r = 0;
    for (int i = 0; i < ADDR_W; i++) r = r * 2 + ((idx >> i) & 1);
`endif
    return ADDR_W'(r);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_snk_ready"}, bus.snk_ready, 0);
    check({tag, "_avm_write"}, bus.avm_write, 0);
    check({tag, "_avm_address"}, bus.avm_address, 0);
    check({tag, "_avm_writedata"}, bus.avm_writedata, 0);
    check({tag, "_avm_byteenable"}, bus.avm_byteenable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_frames_loaded"}, frames_loaded, 0);
  endtask

  // One clock: drive inputs just after the falling edge, check, then advance the model past the next rising edge.
  task automatic step(input bit v, input logic [15:0] d, input bit stall, input bit st, input bit ab);
    bit  exp_rdy;
    bit  xfer;
    wr_t w;
    bus.snk_valid       = v;
    bus.snk_data        = d;
    bus.avm_waitrequest = stall;
    start               = st;
    abort               = ab;
    #1;
    exp_rdy = (m_phase == M_CAP) && !ab && !(m_pend && stall);
    check("snk_ready", bus.snk_ready, exp_rdy);
    check("busy", busy, m_phase != M_IDLE);
    check("frames_loaded", frames_loaded, m_frames);
    check("avm_write", bus.avm_write, m_pend);
    xfer = v && exp_rdy;
    if (xfer) begin
      w.addr = exp_addr(m_cnt);
      w.data = {16'h0000, d};
      wr_q.push_back(w);
      if (m_cnt == 0) first_xfer_cyc = cyc;
      m_pend_idx = m_cnt;
    end
    case (m_phase)
      M_IDLE: if (st) begin
        m_phase = M_CAP; m_cnt = 0; m_aborted = 1'b0;
      end
      M_CAP: if (ab) begin
        m_aborted = 1'b1; m_phase = M_FLUSH;
      end else if (xfer) begin
        m_cnt++;
        if (m_cnt == N) m_phase = M_FLUSH;
      end
      M_FLUSH: if (ab) m_aborted = 1'b1;
      default: ;
    endcase
    m_pend = xfer || (m_pend && stall);
    if (m_phase == M_FLUSH && !m_pend) begin
      if (!m_aborted) begin
        m_frames = (m_frames + 1) & 16'hFFFF;
        done_q.push_back(cyc + 1);
      end
      m_phase = M_IDLE;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #3 reset_n = 1'b0;
    #1 check_zero("async_reset");
    wr_q.delete();
    done_q.delete();
    m_phase = M_IDLE; m_pend = 1'b0; m_frames = 0; m_cnt = 0; m_aborted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // smode: 0 none, 1 random stalls, 2 three-cycle stall on sample 5, 3 three-cycle stall at abort_at with abort.
  task automatic run_frame(input bit rnd, input int smode, input int abort_at, input int reset_at);
    int          budget;
    int          stall_left;
    bit          ab_done;
    bit          st_done;
    bit          v, s, st, ab;
    logic [15:0] d;
    budget = 20000; stall_left = 3; ab_done = 1'b0; st_done = 1'b0;
    step(1'b1, 16'hBEEF, 1'b0, 1'b1, abort_at >= 0);
    while (m_phase != M_IDLE && budget > 0) begin
      budget--;
      if (reset_at >= 0 && m_cnt >= reset_at) begin
        do_reset();
        break;
      end
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      d  = rnd ? 16'($urandom) : 16'(m_cnt);
      st = 1'b0;
      ab = 1'b0;
      case (smode)
        1:       s = ($urandom_range(0, 3) == 0);
        2:       s = m_pend && (m_pend_idx == 5) && (stall_left > 0);
        3:       s = m_pend && (m_cnt >= abort_at) && (stall_left > 0);
        default: s = 1'b0;
      endcase
      if (s && smode >= 2) stall_left--;
      if (smode == 3 && s && !ab_done) begin
        ab = 1'b1; ab_done = 1'b1;
      end
      if (smode == 1 && m_cnt == 100 && !st_done) begin
        st = 1'b1; st_done = 1'b1;
      end
      step(v, d, s, st, ab);
    end
    check("frame_within_budget", budget > 0, 1);
    repeat (2) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    wr_t               e;
    bit                prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_write", bus.avm_write, 1);
          check("stall_hold_address", bus.avm_address, prev_addr);
          check("stall_hold_data", bus.avm_writedata, prev_data);
        end
        check("byteenable", bus.avm_byteenable, bus.avm_write ? 4'hF : 4'h0);
        if (bus.avm_write && !bus.avm_waitrequest) begin
          if (wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write", bus.avm_address, bus.avm_writedata);
          end else begin
            e = wr_q.pop_front();
            check("write_address", bus.avm_address, e.addr);
            check("write_data", bus.avm_writedata, e.data);
          end
        end
        if (done) begin
          done_seen_cyc = cyc;
          if (done_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
          end else begin
            check("done_cycle", cyc, done_q.pop_front());
          end
        end
        prev_stall = bus.avm_write && bus.avm_waitrequest;
        prev_addr  = bus.avm_address;
        prev_data  = bus.avm_writedata;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.snk_valid = 1'b0; bus.snk_data = 16'h0000; bus.avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    repeat (4) step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 0, -1, -1);
    check("frame1_done_latency", done_seen_cyc - first_xfer_cyc, N + 1);
    check("frame1_count", frames_loaded, 1);
    run_frame(1'b1, 2, -1, -1);
    run_frame(1'b1, 1, -1, -1);
    run_frame(1'b1, 3, 300, -1);
    check("after_abort_count", frames_loaded, 3);
    run_frame(1'b0, 0, -1, -1);
    run_frame(1'b1, 1, -1, 200);
    check("after_reset_count", frames_loaded, 0);
    run_frame(1'b1, 1, -1, -1);
    repeat (4) step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1);
    check("final_count", frames_loaded, 1);
    check("writes_outstanding", wr_q.size(), 0);
    check("done_outstanding", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
